// File: rtl/serial_rx_frame.sv
// Serial frame receiver: start / data / optional parity / stop bits, one bit per clk.
// Delivers good words through a one-entry valid/ready holding register and pulses error flags.
module serial_rx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int LSB_FIRST  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DATA   = 3'd1;
  localparam logic [2:0] S_PARITY = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bad;
  logic [DATA_BITS-1:0] r_out_data;
  logic                 r_out_valid;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic [DATA_BITS-1:0] w_shift_next;
  logic                 w_last_data;
  logic                 w_last_stop;
  logic                 w_par_bad;
  logic                 w_done;
  logic                 w_good;
  logic                 w_load;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    w_shift_next = r_shift;
    if (LSB_FIRST != 0) w_shift_next = {in, r_shift[DATA_BITS-1:1]};
    else                w_shift_next = {r_shift[DATA_BITS-2:0], in};
  end

  assign w_last_data = (r_bit_cnt == CNT_W'(DATA_BITS - 1));
  assign w_last_stop = (r_bit_cnt == CNT_W'(STOP_BITS - 1));
  // Even parity wants XOR(data, parity) == 0, odd wants 1.
  assign w_par_bad   = (^r_shift) ^ in ^ 1'(PARITY_ODD);
  assign w_done      = (r_state == S_STOP) && in && w_last_stop;
  assign w_good      = w_done && !r_par_bad;
  assign w_load      = w_good && (!r_out_valid || out_ready);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par_bad <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!in) begin
            r_state   <= S_DATA;
            r_bit_cnt <= '0;
            r_par_bad <= 1'b0;
          end
        end
        S_DATA: begin
          r_shift <= w_shift_next;
          if (w_last_data) begin
            r_bit_cnt <= '0;
            r_state   <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        S_PARITY: begin
          r_par_bad <= w_par_bad;
          r_bit_cnt <= '0;
          r_state   <= S_STOP;
        end
        S_STOP: begin
          if (!in)              r_state   <= S_ERROR;
          else if (w_last_stop) r_state   <= S_IDLE;
          else                  r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
        S_ERROR: begin
          if (in) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Holding register and the three mutually exclusive error pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_parity_err <= w_done && r_par_bad;
      r_frame_err  <= (r_state == S_STOP) && !in;
      r_overrun    <= w_good && r_out_valid && !out_ready;
      if (w_load) begin
        r_out_data  <= r_shift;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_serial_rx_frame.sv
// Randomized frame-level bench for serial_rx_frame on three parameter sets,
// each compared against an expected-outcome model of frames and the holding register.
module tb_serial_rx_frame;

  localparam logic [1:0] T_NONE = 2'd0;
  localparam logic [1:0] T_GOOD = 2'd1;
  localparam logic [1:0] T_PERR = 2'd2;
  localparam logic [1:0] T_FERR = 2'd3;

  typedef struct {
    logic        b;
    logic [1:0]  tag;
    logic [15:0] word;
  } sbit_t;

  logic clk;
  logic reset_n;
  logic r_in  [3];
  logic r_rdy [3];

  logic [7:0] w_data0;
  logic [7:0] w_data1;
  logic [8:0] w_data2;
  logic [15:0] w_data [3];
  logic w_valid [3];
  logic w_perr  [3];
  logic w_ferr  [3];
  logic w_ovr   [3];

  // Lane configuration: 0 = defaults, 1 = even parity, 2 = 9 bits / odd parity / 2 stops / MSB first
  int db_c  [3] = '{8, 8, 9};
  int pen_c [3] = '{0, 1, 1};
  int odd_c [3] = '{0, 0, 1};
  int sb_c  [3] = '{1, 1, 2};
  int lsb_c [3] = '{1, 1, 0};

  sbit_t q_bits [3][$];
  logic        ev   [3];
  logic [15:0] ed   [3];
  logic        ep_p [3];
  logic        ep_f [3];
  logic        ep_o [3];

  int n_vec;
  int n_err;

  serial_rx_frame u_rx0 (
    .clk(clk), .reset_n(reset_n), .in(r_in[0]), .out_data(w_data0), .out_valid(w_valid[0]),
    .out_ready(r_rdy[0]), .parity_err(w_perr[0]), .frame_err(w_ferr[0]), .overrun(w_ovr[0])
  );

  serial_rx_frame #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .LSB_FIRST(1)) u_rx1 (
    .clk(clk), .reset_n(reset_n), .in(r_in[1]), .out_data(w_data1), .out_valid(w_valid[1]),
    .out_ready(r_rdy[1]), .parity_err(w_perr[1]), .frame_err(w_ferr[1]), .overrun(w_ovr[1])
  );

  serial_rx_frame #(.DATA_BITS(9), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2), .LSB_FIRST(0)) u_rx2 (
    .clk(clk), .reset_n(reset_n), .in(r_in[2]), .out_data(w_data2), .out_valid(w_valid[2]),
    .out_ready(r_rdy[2]), .parity_err(w_perr[2]), .frame_err(w_ferr[2]), .overrun(w_ovr[2])
  );

  assign w_data[0] = {8'b0, w_data0};
  assign w_data[1] = {8'b0, w_data1};
  assign w_data[2] = {7'b0, w_data2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_bit(input int ln, input logic b, input logic [1:0] tag, input logic [15:0] w);
    sbit_t e;
    e.b    = b;
    e.tag  = tag;
    e.word = w;
    q_bits[ln].push_back(e);
  endtask

  // Serialise one frame; the completion tag sits on the bit that decides the frame's outcome.
  task automatic push_frame(input int ln, input logic [15:0] w, input logic [1:0] kind,
                            input int gap, input int bad_idx, input int nz);
    logic p;
    for (int i = 0; i < gap; i++) push_bit(ln, 1'b1, T_NONE, 16'h0);
    push_bit(ln, 1'b0, T_NONE, 16'h0);
    for (int i = 0; i < db_c[ln]; i++)
      push_bit(ln, (lsb_c[ln] != 0) ? w[i] : w[db_c[ln]-1-i], T_NONE, 16'h0);
    if (pen_c[ln] != 0) begin
      p = (^w) ^ (odd_c[ln] != 0) ^ (kind == T_PERR);
      push_bit(ln, p, T_NONE, 16'h0);
    end
    if (kind == T_FERR) begin
      for (int j = 0; j < bad_idx; j++) push_bit(ln, 1'b1, T_NONE, 16'h0);
      push_bit(ln, 1'b0, T_FERR, 16'h0);
      for (int j = 0; j < nz; j++) push_bit(ln, 1'b0, T_NONE, 16'h0);
      push_bit(ln, 1'b1, T_NONE, 16'h0);
    end else begin
      for (int j = 0; j < sb_c[ln]; j++)
        push_bit(ln, 1'b1, (j == sb_c[ln]-1) ? kind : T_NONE, w);
    end
  endtask

  task automatic gen_random(input int ln);
    logic [15:0] w;
    logic [1:0]  kind;
    int r;
    w = 16'($urandom) & 16'((1 << db_c[ln]) - 1);
    r = $urandom_range(0, 9);
    if (r < 6)      kind = T_GOOD;
    else if (r < 8) kind = (pen_c[ln] != 0) ? T_PERR : T_GOOD;
    else            kind = T_FERR;
    push_frame(ln, w, kind, $urandom_range(0, 2), $urandom_range(0, sb_c[ln]-1), $urandom_range(0, 4));
  endtask

  task automatic check_outputs(input string when);
    for (int ln = 0; ln < 3; ln++) begin
      check($sformatf("%s_valid%0d", when, ln), 16'(w_valid[ln]), 16'(ev[ln]));
      check($sformatf("%s_data%0d", when, ln), w_data[ln], ed[ln]);
      check($sformatf("%s_perr%0d", when, ln), 16'(w_perr[ln]), 16'(ep_p[ln]));
      check($sformatf("%s_ferr%0d", when, ln), 16'(w_ferr[ln]), 16'(ep_f[ln]));
      check($sformatf("%s_ovr%0d", when, ln), 16'(w_ovr[ln]), 16'(ep_o[ln]));
    end
  endtask

  task automatic clear_model();
    for (int ln = 0; ln < 3; ln++) begin
      q_bits[ln].delete();
      ev[ln] = 1'b0; ed[ln] = 16'h0;
      ep_p[ln] = 1'b0; ep_f[ln] = 1'b0; ep_o[ln] = 1'b0;
      r_in[ln] = 1'b1; r_rdy[ln] = 1'b0;
    end
  endtask

  // Asynchronous reset landing between clock edges, usually in the middle of a frame.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    clear_model();
    check_outputs("rst_async");
    @(posedge clk); #1;
    check_outputs("rst_hold");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Drive one bit per lane and advance the expected holding register / pulse state.
  task automatic drive_cycle();
    sbit_t e;
    logic rdy;
    for (int ln = 0; ln < 3; ln++) begin
      if (q_bits[ln].size() == 0) gen_random(ln);
      e = q_bits[ln].pop_front();
      rdy = ($urandom_range(0, 9) < 6);
      r_in[ln]  = e.b;
      r_rdy[ln] = rdy;
      ep_p[ln] = (e.tag == T_PERR);
      ep_f[ln] = (e.tag == T_FERR);
      ep_o[ln] = (e.tag == T_GOOD) && ev[ln] && !rdy;
      if (e.tag == T_GOOD && (!ev[ln] || rdy)) begin
        ed[ln] = e.word;
        ev[ln] = 1'b1;
      end else if (ev[ln] && rdy) begin
        ev[ln] = 1'b0;
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 check_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    push_frame(0, 16'h004D, T_GOOD, 1, 0, 0);
    push_frame(0, 16'h00A5, T_GOOD, 0, 0, 0);
    push_frame(0, 16'h003C, T_GOOD, 0, 0, 0);
    push_frame(1, 16'h004D, T_PERR, 1, 0, 0);
    push_frame(1, 16'h004D, T_GOOD, 0, 0, 0);
    push_frame(1, 16'h0055, T_FERR, 0, 0, 4);
    push_frame(2, 16'h01C3, T_GOOD, 2, 0, 0);
    push_frame(2, 16'h0101, T_FERR, 0, 1, 5);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      drive_cycle();
      @(posedge clk); #1;
      check_outputs("run");
      if (cyc == 700 || cyc == 1901) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
